// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg: shared voice count, age width and allocator FSM states
package voice_allocator_pkg;
    localparam int NVOICE = 4;
    localparam int AGE_W  = 2;
    localparam int VIDX_W = 2;
    typedef enum logic [1:0] {ST_IDLE, ST_MATCH, ST_APPLY} state_t;
endpackage

// File: rtl/voice_allocator_age_tracker.sv
// voice_age_tracker: keeps voice ages as a permutation of 0..3; a touched voice becomes youngest
module voice_age_tracker
    import voice_allocator_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [NVOICE-1:0] TOUCH,
    output logic [NVOICE-1:0] OLDEST
);
    logic [AGE_W-1:0] age [NVOICE];
    logic [AGE_W-1:0] touched_age;
    // age of the voice being touched (TOUCH is one-hot or zero)
    always_comb begin
        touched_age = '0;
        for (int i = 0; i < NVOICE; i++) touched_age = TOUCH[i] ? age[i] : touched_age;
    end
    // touched voice drops to 0, every younger voice ages by one
    always_ff @(posedge CLK) begin
        if (RST) for (int i = 0; i < NVOICE; i++) age[i] <= AGE_W'(i);
        else if (|TOUCH)
            for (int i = 0; i < NVOICE; i++)
                age[i] <= TOUCH[i] ? '0 : age[i] < touched_age ? age[i] + AGE_W'(1) : age[i];
    end
    // oldest voice carries the maximum age
    always_comb begin
        for (int i = 0; i < NVOICE; i++) OLDEST[i] = age[i] == AGE_W'(NVOICE - 1);
    end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: maps note-on/off events onto 4 nco_bank voices; define VOICE_STEAL_EN to steal the oldest voice when all are busy
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int W_NOTE = 7,
    parameter int W_VEL  = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    input  logic              EV_VALID,
    output logic              EV_READY,
    input  logic              EV_NOTE_ON,
    input  logic [W_NOTE-1:0] EV_NOTE,
    input  logic [W_VEL-1:0]  EV_VEL,
    output logic [W_NOTE-1:0] NOTE_NUM_0,
    output logic [W_NOTE-1:0] NOTE_NUM_1,
    output logic [W_NOTE-1:0] NOTE_NUM_2,
    output logic [W_NOTE-1:0] NOTE_NUM_3,
    output logic [W_VEL-1:0]  NOTE_VEL_0,
    output logic [W_VEL-1:0]  NOTE_VEL_1,
    output logic [W_VEL-1:0]  NOTE_VEL_2,
    output logic [W_VEL-1:0]  NOTE_VEL_3,
    output logic [NVOICE-1:0] VOICE_ACTIVE,
    output logic              EV_DROPPED
);
`ifdef VOICE_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif
    state_t state;
    logic ev_on;
    logic [W_NOTE-1:0] ev_note;
    logic [W_VEL-1:0] ev_vel;
    logic [W_NOTE-1:0] num [NVOICE];
    logic [W_VEL-1:0] vel [NVOICE];
    logic [NVOICE-1:0] active, oldest, touch;
    logic hit, free_vld, hit_c, free_vld_c;
    logic [VIDX_W-1:0] hit_idx, free_idx, old_idx, hit_idx_c, free_idx_c, old_idx_c, tgt;
    logic apply, do_on, do_off, dropped;

    voice_age_tracker u_age (
        .CLK    (CLK),
        .RST    (RST),
        .TOUCH  (touch),
        .OLDEST (oldest)
    );

    // parallel compare against active voices; downward scan makes the lowest index win
    always_comb begin
        hit_c = 1'b0;
        hit_idx_c = '0;
        free_vld_c = 1'b0;
        free_idx_c = '0;
        old_idx_c = '0;
        for (int i = NVOICE - 1; i >= 0; i--) begin
            if (active[i] && num[i] == ev_note) begin
                hit_c = 1'b1;
                hit_idx_c = VIDX_W'(i);
            end
            if (!active[i]) begin
                free_vld_c = 1'b1;
                free_idx_c = VIDX_W'(i);
            end
            if (oldest[i]) old_idx_c = VIDX_W'(i);
        end
    end

    // decide which voice the latched event updates during APPLY
    always_comb begin
        apply = CE && state == ST_APPLY;
        tgt = hit ? hit_idx : free_vld ? free_idx : old_idx;
        do_on = apply && ev_on && (hit || free_vld || STEAL_EN);
        do_off = apply && !ev_on && hit;
        touch = do_on ? NVOICE'(1) << tgt : '0;
    end

    // IDLE -> MATCH -> APPLY sequencer with event latch and registered match results
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            ev_on <= 1'b0;
            ev_note <= '0;
            ev_vel <= '0;
            hit <= 1'b0;
            hit_idx <= '0;
            free_vld <= 1'b0;
            free_idx <= '0;
            old_idx <= '0;
        end else if (CE) begin
            state <= state == ST_IDLE ? (EV_VALID ? ST_MATCH : ST_IDLE) :
                     state == ST_MATCH ? ST_APPLY : ST_IDLE;
            if (state == ST_IDLE && EV_VALID) begin
                ev_on <= EV_NOTE_ON && |EV_VEL;
                ev_note <= EV_NOTE;
                ev_vel <= EV_VEL;
            end
            if (state == ST_MATCH) begin
                hit <= hit_c;
                hit_idx <= hit_idx_c;
                free_vld <= free_vld_c;
                free_idx <= free_idx_c;
                old_idx <= old_idx_c;
            end
        end
    end

    // one-cycle pulse when an all-busy note-on is thrown away
    always_ff @(posedge CLK) begin
        if (RST) dropped <= 1'b0;
        else dropped <= apply && ev_on && !hit && !free_vld && !STEAL_EN;
    end

    // per-voice note/velocity/active registers; note number survives note-off
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NVOICE; i++) begin
                num[i] <= '0;
                vel[i] <= '0;
            end
            active <= '0;
        end else if (do_on) begin
            num[tgt] <= ev_note;
            vel[tgt] <= ev_vel;
            active[tgt] <= 1'b1;
        end else if (do_off) begin
            vel[tgt] <= '0;
            active[tgt] <= 1'b0;
        end
    end

    assign EV_READY = CE && state == ST_IDLE;
    assign EV_DROPPED = dropped;
    assign VOICE_ACTIVE = active;
    assign NOTE_NUM_0 = num[0];
    assign NOTE_NUM_1 = num[1];
    assign NOTE_NUM_2 = num[2];
    assign NOTE_NUM_3 = num[3];
    assign NOTE_VEL_0 = vel[0];
    assign NOTE_VEL_1 = vel[1];
    assign NOTE_VEL_2 = vel[2];
    assign NOTE_VEL_3 = vel[3];
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed vector table plus latency, CE, streaming and reset sequences
module tb_voice_allocator;
`ifdef VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif
    logic CLK = 1'b0, RST = 1'b1, CE = 1'b1, EV_VALID = 1'b0, EV_NOTE_ON = 1'b0;
    logic [6:0] EV_NOTE = '0, EV_VEL = '0;
    logic EV_READY, EV_DROPPED;
    logic [6:0] NOTE_NUM_0, NOTE_NUM_1, NOTE_NUM_2, NOTE_NUM_3;
    logic [6:0] NOTE_VEL_0, NOTE_VEL_1, NOTE_VEL_2, NOTE_VEL_3;
    logic [3:0] VOICE_ACTIVE;
    logic [3:0][6:0] nn, nv;
    int checks = 0, errors = 0;

    assign nn = {NOTE_NUM_3, NOTE_NUM_2, NOTE_NUM_1, NOTE_NUM_0};
    assign nv = {NOTE_VEL_3, NOTE_VEL_2, NOTE_VEL_1, NOTE_VEL_0};

    voice_allocator dut (
        .CLK(CLK), .RST(RST), .CE(CE), .EV_VALID(EV_VALID), .EV_READY(EV_READY),
        .EV_NOTE_ON(EV_NOTE_ON), .EV_NOTE(EV_NOTE), .EV_VEL(EV_VEL),
        .NOTE_NUM_0(NOTE_NUM_0), .NOTE_NUM_1(NOTE_NUM_1), .NOTE_NUM_2(NOTE_NUM_2), .NOTE_NUM_3(NOTE_NUM_3),
        .NOTE_VEL_0(NOTE_VEL_0), .NOTE_VEL_1(NOTE_VEL_1), .NOTE_VEL_2(NOTE_VEL_2), .NOTE_VEL_3(NOTE_VEL_3),
        .VOICE_ACTIVE(VOICE_ACTIVE), .EV_DROPPED(EV_DROPPED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic on;
        logic [6:0] note;
        logic [6:0] vel;
        logic [3:0][6:0] en;
        logic [3:0][6:0] ev;
        logic [3:0] act;
        int drop;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [3:0][6:0] q(input int a, input int b, input int c, input int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    function automatic vec_t mk(input logic on, input int note, input int vel,
                                input logic [3:0][6:0] en, input logic [3:0][6:0] ev,
                                input logic [3:0] act, input int drop);
        vec_t v;
        v.on = on;
        v.note = 7'(note);
        v.vel = 7'(vel);
        v.en = en;
        v.ev = ev;
        v.act = act;
        v.drop = drop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        EV_VALID = 1'b0;
        CE = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // called at a negedge; returns at the negedge after the APPLY edge
    task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v, output int drops);
        int w = 0;
        drops = 0;
        while (!EV_READY && w < 20) begin
            @(negedge CLK);
            w++;
        end
        if (!EV_READY) chk("ready_timeout", 0, 1);
        EV_VALID = 1'b1;
        EV_NOTE_ON = on;
        EV_NOTE = n;
        EV_VEL = v;
        @(negedge CLK);
        EV_VALID = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            drops += int'(EV_DROPPED);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int a, b, c, d, dr, k;
        a = STEAL ? 72 : 60;
        b = STEAL ? 90 : 80;
        c = STEAL ? 72 : 71;
        d = STEAL ? 90 : 80;
        dr = STEAL ? 0 : 1;
        tbl[0]  = mk(1, 60, 100, q(60, 0, 0, 0),    q(100, 0, 0, 0),   4'b0001, 0);
        tbl[1]  = mk(1, 60, 80,  q(60, 0, 0, 0),    q(80, 0, 0, 0),    4'b0001, 0);
        tbl[2]  = mk(1, 64, 80,  q(60, 64, 0, 0),   q(80, 80, 0, 0),   4'b0011, 0);
        tbl[3]  = mk(1, 67, 80,  q(60, 64, 67, 0),  q(80, 80, 80, 0),  4'b0111, 0);
        tbl[4]  = mk(1, 71, 80,  q(60, 64, 67, 71), q(80, 80, 80, 80), 4'b1111, 0);
        tbl[5]  = mk(1, 72, 90,  q(a, 64, 67, 71),  q(b, 80, 80, 80),  4'b1111, dr);
        tbl[6]  = mk(0, 64, 5,   q(a, 64, 67, 71),  q(b, 0, 80, 80),   4'b1101, 0);
        tbl[7]  = mk(1, 50, 70,  q(a, 50, 67, 71),  q(b, 70, 80, 80),  4'b1111, 0);
        tbl[8]  = mk(1, a, 0,    q(a, 50, 67, 71),  q(0, 70, 80, 80),  4'b1110, 0);
        tbl[9]  = mk(0, 99, 0,   q(a, 50, 67, 71),  q(0, 70, 80, 80),  4'b1110, 0);
        tbl[10] = mk(1, 67, 20,  q(a, 50, 67, 71),  q(0, 70, 20, 80),  4'b1110, 0);
        tbl[11] = mk(1, 40, 55,  q(40, 50, 67, 71), q(55, 70, 20, 80), 4'b1111, 0);
        tbl[12] = mk(1, 72, 90,  q(40, 50, 67, c),  q(55, 70, 20, d),  4'b1111, dr);

        do_reset();
        chk("reset_active", 32'(VOICE_ACTIVE), 0);
        chk("reset_num", 32'(nn), 0);
        chk("reset_vel", 32'(nv), 0);
        chk("reset_dropped", 32'(EV_DROPPED), 0);
        chk("reset_ready", 32'(EV_READY), 1);

        for (int r = 0; r < 13; r++) begin
            int drops;
            send(tbl[r].on, tbl[r].note, tbl[r].vel, drops);
            for (int v = 0; v < 4; v++) begin
                chk($sformatf("row%0d_num%0d", r, v), 32'(nn[v]), 32'(tbl[r].en[v]));
                chk($sformatf("row%0d_vel%0d", r, v), 32'(nv[v]), 32'(tbl[r].ev[v]));
            end
            chk($sformatf("row%0d_active", r), 32'(VOICE_ACTIVE), 32'(tbl[r].act));
            chk($sformatf("row%0d_drops", r), 32'(drops), 32'(tbl[r].drop));
        end

        do_reset();
        EV_VALID = 1'b1;
        EV_NOTE_ON = 1'b1;
        EV_NOTE = 7'd5;
        EV_VEL = 7'd9;
        @(negedge CLK);
        EV_VALID = 1'b0;
        chk("lat_ready_busy", 32'(EV_READY), 0);
        @(negedge CLK);
        chk("lat_edge1_vel", 32'(NOTE_VEL_0), 0);
        @(negedge CLK);
        chk("lat_edge2_vel", 32'(NOTE_VEL_0), 9);
        chk("lat_edge2_num", 32'(NOTE_NUM_0), 5);

        do_reset();
        EV_VALID = 1'b1;
        EV_NOTE = 7'd33;
        EV_VEL = 7'd44;
        @(negedge CLK);
        EV_VALID = 1'b0;
        CE = 1'b0;
        repeat (3) @(negedge CLK);
        chk("ce_ready_low", 32'(EV_READY), 0);
        chk("ce_frozen_active", 32'(VOICE_ACTIVE), 0);
        CE = 1'b1;
        @(negedge CLK);
        chk("ce_resume_not_yet", 32'(VOICE_ACTIVE), 0);
        @(negedge CLK);
        chk("ce_resume_num", 32'(NOTE_NUM_0), 33);
        chk("ce_resume_vel", 32'(NOTE_VEL_0), 44);
        chk("ce_resume_active", 32'(VOICE_ACTIVE), 1);

        do_reset();
        k = 0;
        EV_VALID = 1'b1;
        EV_NOTE_ON = 1'b1;
        for (int cy = 0; cy < 12; cy++) begin
            chk($sformatf("stream_ready_c%0d", cy), 32'(EV_READY), 32'(cy % 3 == 0));
            if (EV_READY) begin
                EV_NOTE = 7'(10 + k);
                EV_VEL = 7'(1 + k);
                k++;
            end
            @(negedge CLK);
        end
        EV_VALID = 1'b0;
        chk("stream_count", 32'(k), 4);
        chk("stream_num", 32'(nn), 32'(q(10, 11, 12, 13)));
        chk("stream_vel", 32'(nv), 32'(q(1, 2, 3, 4)));
        chk("stream_active", 32'(VOICE_ACTIVE), 4'b1111);

        @(negedge CLK);
        EV_VALID = 1'b1;
        EV_NOTE_ON = 1'b0;
        EV_NOTE = 7'd10;
        @(negedge CLK);
        EV_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_apply_active", 32'(VOICE_ACTIVE), 0);
        chk("rst_apply_num", 32'(nn), 0);
        chk("rst_apply_vel", 32'(nv), 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_apply_ready", 32'(EV_READY), 1);
        begin
            int drops;
            send(1'b1, 7'd20, 7'd30, drops);
            chk("rst_after_num", 32'(NOTE_NUM_0), 20);
            chk("rst_after_vel", 32'(NOTE_VEL_0), 30);
            chk("rst_after_active", 32'(VOICE_ACTIVE), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
